// File: rtl/i2c_master_ctrl.sv
// Write-only I2C master sequencer: START, {addr,0}, ACK, wdata, ACK, STOP.
// Drives SCL directly and steers SDA through sda_mode; an external data unit shifts the bytes.
module i2c_master_ctrl #(
    parameter int HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       iSDA,
    output logic       go,
    output logic       dbit,
    output logic [7:0] du_data,
    output logic       scl,
    output logic [1:0] sda_mode,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [2:0] o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_LOAD, S_BIT, S_ACK, S_STOP, S_DONE
    } state_t;

    localparam int              DW       = (HALF > 2) ? $clog2(HALF) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(HALF - 1);
    localparam logic [DW-1:0]   DIV_PRE  = DW'(HALF - 2);
    localparam logic [1:0]      SDA_REL  = 2'b00;
    localparam logic [1:0]      SDA_LOW  = 2'b01;
    localparam logic [1:0]      SDA_DU   = 2'b10;

    state_t          r_state;
    logic [DW-1:0]   r_div;
    logic [1:0]      r_ph;
    logic [2:0]      r_bit;
    logic            r_byte;
    logic [6:0]      r_addr;
    logic [7:0]      r_wdata;
    logic            r_go;
    logic            r_dbit;
    logic [7:0]      r_du_data;
    logic            r_scl;
    logic [1:0]      r_sda_mode;
    logic            r_busy;
    logic            r_done;
    logic            r_ack_err;
    logic            w_div_end;

    assign w_div_end = (r_div == DIV_LAST);

    // go and dbit are single-cycle strobes to the data unit; it loads du_data on go
    // and shifts one bit on dbit, so its MSB is what SDA carries while sda_mode=10.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_ph       <= '0;
            r_bit      <= '0;
            r_byte     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_go       <= 1'b0;
            r_dbit     <= 1'b0;
            r_du_data  <= '0;
            r_scl      <= 1'b1;
            r_sda_mode <= SDA_REL;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            r_go   <= 1'b0;
            r_dbit <= 1'b0;
            r_done <= 1'b0;
            r_div  <= w_div_end ? '0 : r_div + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_div <= '0;
                    if (start) begin
                        r_state   <= S_START;
                        r_addr    <= addr;
                        r_wdata   <= wdata;
                        r_ack_err <= 1'b0;
                        r_busy    <= 1'b1;
                        r_ph      <= '0;
                        r_bit     <= '0;
                        r_byte    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_div_end) begin
                        if (r_ph == 2'd0) begin
                            r_ph       <= 2'd1;
                            r_sda_mode <= SDA_LOW;
                        end else begin
                            r_state   <= S_LOAD;
                            r_ph      <= '0;
                            r_scl     <= 1'b0;
                            r_go      <= 1'b1;
                            r_du_data <= r_byte ? r_wdata : {r_addr, 1'b0};
                        end
                    end
                end
                S_LOAD: begin
                    r_state    <= S_BIT;
                    r_div      <= '0;
                    r_ph       <= '0;
                    r_bit      <= '0;
                    r_sda_mode <= SDA_DU;
                end
                S_BIT: begin
                    // Registered strobe lands on the last SCL-high cycle of bits 0..6.
                    if (r_ph == 2'd1 && r_div == DIV_PRE && r_bit != 3'd7)
                        r_dbit <= 1'b1;
                    if (w_div_end) begin
                        if (r_ph == 2'd0) begin
                            r_ph  <= 2'd1;
                            r_scl <= 1'b1;
                        end else begin
                            r_ph  <= '0;
                            r_scl <= 1'b0;
                            if (r_bit == 3'd7) begin
                                r_state    <= S_ACK;
                                r_sda_mode <= SDA_REL;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (w_div_end) begin
                        if (r_ph == 2'd0) begin
                            r_ph  <= 2'd1;
                            r_scl <= 1'b1;
                        end else begin
                            r_ph  <= '0;
                            r_scl <= 1'b0;
                            if (iSDA) begin
                                r_ack_err  <= 1'b1;
                                r_state    <= S_STOP;
                                r_sda_mode <= SDA_LOW;
                            end else if (!r_byte) begin
                                r_byte    <= 1'b1;
                                r_state   <= S_LOAD;
                                r_go      <= 1'b1;
                                r_du_data <= r_wdata;
                            end else begin
                                r_state    <= S_STOP;
                                r_sda_mode <= SDA_LOW;
                            end
                        end
                    end
                end
                S_STOP: begin
                    if (w_div_end) begin
                        if (r_ph == 2'd0) begin
                            r_ph  <= 2'd1;
                            r_scl <= 1'b1;
                        end else if (r_ph == 2'd1) begin
                            r_ph       <= 2'd2;
                            r_sda_mode <= SDA_REL;
                        end else begin
                            r_ph    <= '0;
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_div   <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign go          = r_go;
    assign dbit        = r_dbit;
    assign du_data     = r_du_data;
    assign scl         = r_scl;
    assign sda_mode    = r_sda_mode;
    assign busy        = r_busy;
    assign done        = r_done;
    assign ack_err     = r_ack_err;
    assign o_dbg_state = r_state;

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 Parameter HALF, default 4: clk cycles per SCL half-period; legal values are 2 or more.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  transaction request; sampled only in IDLE.
REQ-005 addr  in  7  7-bit slave address; captured when start is accepted.
REQ-006 wdata  in  8  data byte to write; captured when start is accepted.
REQ-007 iSDA  in  1  sampled SDA line level, used for ACK detection.
REQ-008 go  out  1  one-cycle pulse that loads du_data into the data unit shifter.
REQ-009 dbit  out  1  one-cycle pulse that advances the data unit shifter by one bit.
REQ-010 du_data  out  8  byte presented to the data unit; valid while go=1.
REQ-011 scl  out  1  SCL level (1 = released/high).
REQ-012 sda_mode  out  2  SDA source select: 00 = release (high), 01 = drive low, 10 = pass the data unit oSDA.
REQ-013 busy  out  1  high from start acceptance until done.
REQ-014 done  out  1  one-cycle pulse at transaction end.
REQ-015 ack_err  out  1  high if a NACK was received in the last transaction.

Function
REQ-016 Supported transaction: write-only sequence START, {addr,0}, ACK, wdata, ACK, STOP.
REQ-017 States: IDLE, START, LOAD, BIT, ACK, STOP, DONE.
REQ-018 A divider counter times every phase in units of HALF clocks; the bit counter covers 0..7; a byte index selects 0 = address, 1 = data.
REQ-019 IDLE behaviour: scl=1, sda_mode=00, go=0, dbit=0, busy=0.
REQ-020 IDLE exit: when start=1, capture addr and wdata, clear ack_err, and go to START on the next cycle (busy=1 from that cycle).
REQ-021 A start pulse while busy=1 is ignored, with no effect on the transaction.
REQ-022 START: HALF cycles with scl=1 and sda_mode=00, then HALF cycles with scl=1 and sda_mode=01, then go to LOAD.
REQ-023 LOAD: lasts 1 cycle with scl=0 and go=1.
REQ-024 LOAD data: du_data = {addr,1'b0} when byte index is 0, otherwise wdata.
REQ-025 BIT: 8 bits, each 2*HALF cycles, with sda_mode=10 throughout; each bit drives scl=0 for HALF cycles, then scl=1 for HALF cycles.
REQ-026 BIT dbit pulses: dbit=1 on the last cycle of the scl-high phase for bits 0..6 only (7 pulses per byte); after bit 7, go to ACK.
REQ-027 ACK timing: scl=0 for HALF cycles, then scl=1 for HALF cycles, with sda_mode=00 throughout.
REQ-028 ACK sampling: iSDA is sampled on the last scl-high cycle.
REQ-029 ACK outcome: iSDA=1 sets ack_err=1 and goes to STOP; iSDA=0 with byte index 0 sets byte index to 1 and goes to LOAD; iSDA=0 with byte index 1 goes to STOP.
REQ-030 STOP: HALF cycles with scl=0 and sda_mode=01, then HALF cycles with scl=1 and sda_mode=01, then HALF cycles with scl=1 and sda_mode=00, then go to DONE.
REQ-031 DONE: lasts 1 cycle with done=1 and busy=0, then returns to IDLE; ack_err holds until the next accepted start.
REQ-032 Latency, full ACKed transaction: with the start-sampling edge as cycle 0, done=1 in cycle 41*HALF+3.
REQ-033 Latency, address NACK: done=1 in cycle 23*HALF+2.
REQ-034 scl and sda_mode are registered outputs, glitch-free; SDA changes only while scl=0, except during START and STOP.

Reset
REQ-035 While rst=0: state=IDLE, scl=1, sda_mode=00, go=0, dbit=0, du_data=0, busy=0, done=0, ack_err=0, all counters 0.
REQ-036 Reset asserted mid-transaction aborts immediately and releases the bus; no STOP is generated.
REQ-037 After rst deasserts, the first start is accepted normally.

Verification
REQ-038 HALF=4, addr=7'h3A, wdata=8'h7B, iSDA=0 at both ACKs -> go pulses with du_data=8'h74, then 8'h7B; 14 dbit pulses in total; done at cycle 167; ack_err=0.
REQ-039 Same stimulus but iSDA=1 at the address ACK -> no second go, STOP follows, done at cycle 94, ack_err=1.
REQ-040 start re-pulsed at cycle 50 of an active transaction -> waveform identical to REQ-038, and exactly one done.
REQ-041 rst=0 asserted at cycle 60 -> outputs at reset values asynchronously (before the next clk edge); new start after release -> full REQ-038 sequence.
REQ-042 HALF=2 back-to-back transactions (start asserted in the cycle after done) -> second START begins 1 cycle after the return to IDLE; ack_err cleared at that acceptance.
REQ-043 Protocol monitor on scl and the resolved SDA -> exactly one START (SDA falls while SCL high) and one STOP (SDA rises while SCL high) per transaction, and no SDA change while scl=1 elsewhere.
